// File: rtl/ppu_tile_sequencer_if.sv
// rtl/ppu_tile_sequencer_if.sv - frame control, load-FSM handshake and group coordinate bundle
interface ppu_tile_sequencer_if;
    logic        frame_start;
    logic [7:0]  scroll_x;
    logic [7:0]  scroll_y;
    logic [1:0]  base_nt;
    logic        fsm_busy;
    logic        fsm_start;
    logic [8:0]  curr_row;
    logic [8:0]  curr_col;
    logic [15:0] nametable_ptr;
    logic [15:0] attr_ptr;
    logic [1:0]  attr_shift;
    logic [2:0]  pattern_table_offset;
    logic        in_frame;
    logic        frame_done;

    modport master (
        input  frame_start, scroll_x, scroll_y, base_nt, fsm_busy,
        output fsm_start, curr_row, curr_col, nametable_ptr, attr_ptr,
               attr_shift, pattern_table_offset, in_frame, frame_done
    );

    modport slave (
        output frame_start, scroll_x, scroll_y, base_nt, fsm_busy,
        input  fsm_start, curr_row, curr_col, nametable_ptr, attr_ptr,
               attr_shift, pattern_table_offset, in_frame, frame_done
    );
endinterface

// File: rtl/ppu_tile_sequencer.sv
// rtl/ppu_tile_sequencer.sv - row-major 8-pixel group scheduler feeding the PPU VRAM load FSM
module ppu_tile_sequencer #(
    parameter int          NUM_ROWS    = 240,
    parameter logic [15:0] NT_BASE     = 16'h2000,
    parameter logic [15:0] ATTR_OFFSET = 16'h03C0
) (
    input logic                  clk,
    input logic                  rst,
    ppu_tile_sequencer_if.master bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, ACK, WAIT, ADVANCE} state_t;

    state_t      state, state_next;
    logic        accept, issue, advance, last_group;

    logic [2:0]  fx_q;
    logic [4:0]  cx0_q;
    logic [7:0]  sy_q;
    logic        ntx_q, nty_q;
    logic [8:0]  row_q;
    logic [5:0]  grp_q;
    logic [5:0]  last_grp;

    logic [2:0]  f_fx;
    logic [4:0]  f_cx0;
    logic [7:0]  f_sy, sy_clamped;
    logic        f_ntx, f_nty;
    logic [8:0]  row_n;
    logic [5:0]  grp_n;
    logic [5:0]  t;
    logic        hbit, vbit, wrap;
    logic [8:0]  wy_raw;
    logic [7:0]  wy;
    logic [4:0]  cx, cy;
    logic [15:0] nt_off;
    logic [8:0]  col_n;
    logic [15:0] ntp_n, atp_n;

    logic        start_q, done_q, in_frame_q;
    logic [8:0]  row_o, col_o;
    logic [15:0] ntp_o, atp_o;
    logic [1:0]  shift_o;
    logic [2:0]  pto_o;

    assign last_grp   = (fx_q == 3'd0) ? 6'd31 : 6'd32;
    assign last_group = (row_q == 9'(NUM_ROWS - 1)) && (grp_q == last_grp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: if (bus.frame_start) begin
                accept     = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: if (!bus.fsm_busy) begin
                issue      = 1'b1;
                state_next = ACK;
            end
            // load FSM raises busy one cycle after start, so skip a cycle before watching it
            ACK:  state_next = WAIT;
            WAIT: if (!bus.fsm_busy) state_next = ADVANCE;
            ADVANCE: begin
                advance    = 1'b1;
                state_next = last_group ? IDLE : ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Coordinates of the group about to be presented; on acceptance the raw inputs stand in for the latches.
    always_comb begin
        sy_clamped = (bus.scroll_y < 8'd240) ? bus.scroll_y : 8'd239;
        f_fx  = accept ? bus.scroll_x[2:0] : fx_q;
        f_cx0 = accept ? bus.scroll_x[7:3] : cx0_q;
        f_sy  = accept ? sy_clamped        : sy_q;
        f_ntx = accept ? bus.base_nt[0]    : ntx_q;
        f_nty = accept ? bus.base_nt[1]    : nty_q;

        if (accept) begin
            row_n = '0;
            grp_n = '0;
        end else if (grp_q == last_grp) begin
            row_n = row_q + 9'd1;
            grp_n = '0;
        end else begin
            row_n = row_q;
            grp_n = grp_q + 6'd1;
        end

        t      = {1'b0, f_cx0} + grp_n;
        cx     = t[4:0];
        hbit   = f_ntx ^ t[5];
        wy_raw = row_n + {1'b0, f_sy};
        wrap   = (wy_raw >= 9'd240);
        wy     = wrap ? 8'(wy_raw - 9'd240) : wy_raw[7:0];
        vbit   = f_nty ^ wrap;
        cy     = wy[7:3];
        nt_off = {4'b0000, vbit, hbit, 10'b0};
        ntp_n  = NT_BASE + nt_off + {6'b0, cy, cx};
        atp_n  = NT_BASE + nt_off + ATTR_OFFSET + {10'b0, cy[4:2], cx[4:2]};
        col_n  = {grp_n, 3'b000} - {6'b0, f_fx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fx_q       <= '0;
            cx0_q      <= '0;
            sy_q       <= '0;
            ntx_q      <= 1'b0;
            nty_q      <= 1'b0;
            row_q      <= '0;
            grp_q      <= '0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            in_frame_q <= 1'b0;
            row_o      <= '0;
            col_o      <= '0;
            ntp_o      <= '0;
            atp_o      <= '0;
            shift_o    <= '0;
            pto_o      <= '0;
        end else begin
            start_q <= issue;
            done_q  <= advance && last_group;
            if (accept) begin
                fx_q       <= bus.scroll_x[2:0];
                cx0_q      <= bus.scroll_x[7:3];
                sy_q       <= sy_clamped;
                ntx_q      <= bus.base_nt[0];
                nty_q      <= bus.base_nt[1];
                in_frame_q <= 1'b1;
            end
            if (accept || (advance && !last_group)) begin
                row_q   <= row_n;
                grp_q   <= grp_n;
                row_o   <= row_n;
                col_o   <= col_n;
                ntp_o   <= ntp_n;
                atp_o   <= atp_n;
                shift_o <= {cy[1], cx[1]};
                pto_o   <= wy[2:0];
            end
            if (advance && last_group) begin
                in_frame_q <= 1'b0;
                row_q      <= '0;
                grp_q      <= '0;
            end
        end
    end

    assign bus.fsm_start            = start_q;
    assign bus.frame_done           = done_q;
    assign bus.in_frame             = in_frame_q;
    assign bus.curr_row             = row_o;
    assign bus.curr_col             = col_o;
    assign bus.nametable_ptr        = ntp_o;
    assign bus.attr_ptr             = atp_o;
    assign bus.attr_shift           = shift_o;
    assign bus.pattern_table_offset = pto_o;

endmodule

// File: tb/tb_ppu_tile_sequencer.sv
// tb/tb_ppu_tile_sequencer.sv - table, hand-written and randomized checks of ppu_tile_sequencer
module tb_ppu_tile_sequencer;
    localparam int NR = 240;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ppu_tile_sequencer_if bus();

    ppu_tile_sequencer #(.NUM_ROWS(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // load FSM stand-in: busy for a number of cycles starting the cycle after start
    int   busy_len  = 1;
    logic rand_busy = 1'b0;
    logic hold_busy = 1'b0;
    int   busy_cnt  = 0;
    always @(posedge clk) begin
        if (rst)                busy_cnt <= 0;
        else if (bus.fsm_start) busy_cnt <= rand_busy ? int'($urandom_range(6, 1)) : busy_len;
        else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
    end
    assign bus.fsm_busy = hold_busy | (busy_cnt != 0);

    typedef struct {
        int sx, sy, nt, r, g;
        int col, ntp, atp, sh, pto;
    } vec_t;
    vec_t vt[11];

    int vectors = 0, miscompares = 0;
    int start_count = 0, base = 0, done_cnt = 0;
    int m_sx = 0, m_sy = 0, m_nt = 0;
    logic prev_start = 1'b0, in_wait = 1'b0, seen_busy = 1'b0, stab_bad = 1'b0;
    logic [54:0] snap = '0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int grp_count(input int sx);
        return (sx % 8 == 0) ? 32 : 33;
    endfunction

    // Reference: place the group in the 512x480 world map, then split into nametable and tile fields.
    function automatic void model(input int sx, input int sy, input int nt, input int idx,
                                  output int r, output int g, output int col, output int ntp,
                                  output int atp, output int sh, output int pto);
        int gc, syc, wx, wyv, hb, vb, cx, cy, y;
        gc  = grp_count(sx);
        r   = idx / gc;
        g   = idx % gc;
        syc = (sy < 240) ? sy : 239;
        wx  = ((nt % 2) * 256 + (sx / 8) * 8 + 8 * g) % 512;
        hb  = wx / 256;
        cx  = (wx % 256) / 8;
        wyv = ((nt / 2) * 240 + syc + r) % 480;
        vb  = wyv / 240;
        y   = wyv % 240;
        cy  = y / 8;
        col = (8 * g - sx % 8) & 511;
        ntp = 'h2000 + 'h400 * (vb * 2 + hb) + cy * 32 + cx;
        atp = 'h2000 + 'h400 * (vb * 2 + hb) + 'h3C0 + (cy / 4) * 8 + cx / 4;
        sh  = ((cy / 2) % 2) * 2 + (cx / 2) % 2;
        pto = y % 8;
    endfunction

    function automatic logic [54:0] outs();
        return {bus.curr_row, bus.curr_col, bus.nametable_ptr, bus.attr_ptr,
                bus.attr_shift, bus.pattern_table_offset};
    endfunction

    task automatic mon();
        int r, g, col, ntp, atp, sh, pto, idx;
        if (in_wait) begin
            if (outs() != snap) stab_bad = 1'b1;
            if (bus.fsm_busy) seen_busy = 1'b1;
            else if (seen_busy) begin
                in_wait = 1'b0;
                chk("hold_through_wait", int'(stab_bad), 0);
            end
        end
        if (bus.fsm_start) begin
            chk("start_while_busy", int'(bus.fsm_busy), 0);
            chk("start_one_cycle", int'(prev_start), 0);
            chk("in_frame_at_start", int'(bus.in_frame), 1);
            idx = start_count - base;
            start_count++;
            chk("start_in_range", int'(idx < NR * grp_count(m_sx)), 1);
            model(m_sx, m_sy, m_nt, idx, r, g, col, ntp, atp, sh, pto);
            chk("curr_row", int'(bus.curr_row), r);
            chk("curr_col", int'(bus.curr_col), col);
            chk("nametable_ptr", int'(bus.nametable_ptr), ntp);
            chk("attr_ptr", int'(bus.attr_ptr), atp);
            chk("attr_shift", int'(bus.attr_shift), sh);
            chk("pattern_table_offset", int'(bus.pattern_table_offset), pto);
            snap      = outs();
            in_wait   = 1'b1;
            seen_busy = 1'b0;
            stab_bad  = 1'b0;
        end
        prev_start = bus.fsm_start;
        if (bus.frame_done) begin
            done_cnt++;
            chk("in_frame_low_at_done", int'(bus.in_frame), 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fsm_start"}, int'(bus.fsm_start), 0);
        chk({tag, "_in_frame"}, int'(bus.in_frame), 0);
        chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
        chk({tag, "_curr_row"}, int'(bus.curr_row), 0);
        chk({tag, "_curr_col"}, int'(bus.curr_col), 0);
        chk({tag, "_nametable_ptr"}, int'(bus.nametable_ptr), 0);
        chk({tag, "_attr_ptr"}, int'(bus.attr_ptr), 0);
        chk({tag, "_shift_pto"}, int'({bus.attr_shift, bus.pattern_table_offset}), 0);
    endtask

    task automatic start_frame(input int sx, input int sy, input int nt);
        m_sx = sx; m_sy = sy; m_nt = nt;
        base = start_count;
        bus.scroll_x    = 8'(sx);
        bus.scroll_y    = 8'(sy);
        bus.base_nt     = 2'(nt);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int k = 0;
        while ((start_count - base) < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, int'((start_count - base) >= n), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_wait = 1'b0;
        prev_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int k, d0, since;
        vt[0]  = '{0,    0,   0, 0, 0,  'h000, 'h2000, 'h23C0, 0, 0};
        vt[1]  = '{'h0B, 0,   0, 0, 0,  'h1FD, 'h2001, 'h23C0, 0, 0};
        vt[2]  = '{'h0B, 0,   0, 0, 31, 'h0F5, 'h2400, 'h27C0, 0, 0};
        vt[3]  = '{'h0B, 0,   0, 0, 2,  'h00D, 'h2003, 'h23C0, 1, 0};
        vt[4]  = '{0,    232, 0, 7, 0,  'h000, 'h23A0, 'h23F8, 0, 7};
        vt[5]  = '{0,    232, 0, 8, 0,  'h000, 'h2800, 'h2BC0, 0, 0};
        vt[6]  = '{0,    250, 0, 7, 0,  'h000, 'h2800, 'h2BC0, 0, 6};
        vt[7]  = '{0,    239, 0, 7, 0,  'h000, 'h2800, 'h2BC0, 0, 6};
        vt[8]  = '{'h0B, 232, 3, 8, 31, 'h0F5, 'h2000, 'h23C0, 0, 0};
        vt[9]  = '{'hF8, 0,   2, 0, 1,  'h008, 'h2C00, 'h2FC0, 0, 0};
        vt[10] = '{'h13, 29,  1, 3, 5,  'h025, 'h2487, 'h27C9, 1, 0};

        bus.frame_start = 1'b0;
        bus.scroll_x = '0;
        bus.scroll_y = '0;
        bus.base_nt  = '0;

        // reset state, and frame_start while reset is held
        repeat (3) tick();
        chk_zero("reset");
        bus.scroll_x = 8'h55;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        chk_zero("reset_fs");
        rst = 1'b0;
        repeat (3) tick();
        chk("fs_in_reset_ignored_in_frame", int'(bus.in_frame), 0);
        chk("fs_in_reset_ignored_starts", start_count, 0);

        // zero scroll full frame: 10-cycle busy at first, then fast to keep the run short
        busy_len = 10;
        start_frame(0, 0, 0);
        chk("start_before_latency", int'(bus.fsm_start), 0);
        tick();
        chk("first_start_latency", start_count - base, 1);
        run_until(40, 1000, "busy10_groups");
        busy_len = 1;
        run_until(200, 2000, "reach_midframe");
        bus.scroll_x = 8'h5D;
        bus.scroll_y = 8'h77;
        bus.base_nt  = 2'd3;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        k = 0;
        since = -1;
        while (done_cnt == 0 && k < 60000) begin
            tick();
            k++;
            if (since >= 0) since++;
            if (since < 0 && (start_count - base) == 7680) since = 0;
        end
        chk("frame_done_seen", done_cnt, 1);
        chk("starts_per_frame", start_count - base, 7680);
        chk("done_latency_after_last_start", since, 4);
        tick();
        chk("frame_done_one_cycle", int'(bus.frame_done), 0);
        chk("in_frame_after_done", int'(bus.in_frame), 0);
        repeat (5) tick();
        chk("no_start_after_frame", start_count - base, 7680);

        // handshake: busy held on entry to ISSUE
        do_reset();
        busy_len = 10;
        hold_busy = 1'b1;
        start_frame(0, 0, 0);
        repeat (20) tick();
        chk("no_start_while_held", start_count - base, 0);
        chk("in_frame_while_held", int'(bus.in_frame), 1);
        hold_busy = 1'b0;
        run_until(1, 3, "start_after_busy_falls");
        tick();
        chk("start_single_pulse", int'(bus.fsm_start), 0);
        run_until(3, 80, "handshake_groups");

        // table-driven coordinate vectors
        busy_len = 1;
        for (int i = 0; i < 11; i++) begin
            do_reset();
            start_frame(vt[i].sx, vt[i].sy, vt[i].nt);
            run_until(vt[i].r * grp_count(vt[i].sx) + vt[i].g + 1, 4000, "reach_vector");
            chk("vec_row", int'(bus.curr_row), vt[i].r);
            chk("vec_col", int'(bus.curr_col), vt[i].col);
            chk("vec_nametable_ptr", int'(bus.nametable_ptr), vt[i].ntp);
            chk("vec_attr_ptr", int'(bus.attr_ptr), vt[i].atp);
            chk("vec_attr_shift", int'(bus.attr_shift), vt[i].sh);
            chk("vec_pattern_offset", int'(bus.pattern_table_offset), vt[i].pto);
        end

        // randomized scroll/base with random busy lengths
        rand_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_reset();
            start_frame(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
                        int'($urandom_range(3, 0)));
            run_until(int'($urandom_range(120, 40)), 3000, "random_groups");
        end
        rand_busy = 1'b0;

        // abort at row 100, then restart
        do_reset();
        start_frame(0, 0, 0);
        run_until(100 * 32 + 1, 20000, "reach_row100");
        chk("abort_row", int'(bus.curr_row), 100);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk_zero("abort");
        in_wait = 1'b0;
        prev_start = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("no_done_after_abort", done_cnt, d0);
        chk("idle_after_abort", int'(bus.in_frame), 0);
        start_frame('h21, 'h10, 1);
        run_until(1, 4, "restart_first_start");
        chk("restart_row", int'(bus.curr_row), 0);
        chk("restart_col", int'(bus.curr_col), 'h1FF);
        run_until(5, 100, "restart_groups");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
